// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 keyboard receiver driving the 8x5 ZX Spectrum key matrix, with
// active-low column readout for port #FE and one-cycle NMI/reset service requests.
module ps2_keymatrix #(
    parameter int unsigned FILTER_LEN   = 8,
    parameter int unsigned TIMEOUT_BITS = 17
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] addr_hi,
    output logic [4:0] kd,
    output logic       magic_req,
    output logic       reset_req,
    output logic       frame_err
);
    localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    logic [1:0]              clk_sync_q, dat_sync_q;
    logic                    clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
    logic [FiltW-1:0]        clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
    logic                    strobe;
    logic [1:0]              state_q, state_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              shift_q, shift_d, byte_q;
    logic                    par_q, par_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic                    byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
    logic [39:0]             mat_q, mat_d, eff;
    logic [4:0]              cmp_q, cmp_d, cmp_hit, cols;
    logic                    ext_q, ext_d, brk_q, brk_d;
    logic                    magic_q, magic_d, reset_q, reset_d;
    logic [6:0]              key;
    logic [4:0]              kd_q;

    // Row r of the matrix occupies bits [r*5 +: 5]; returns {hit, index}.
    function automatic logic [6:0] map_key(input logic ext, input logic [7:0] code);
        logic       hit;
        logic [5:0] idx;
        hit = 1'b1;
        idx = '0;
        if (ext) begin
            if (code == 8'h14) idx = 6'd36;
            else               hit = 1'b0;
        end else begin
            case (code)
                8'h12: idx = 6'd0;   8'h1a: idx = 6'd1;   8'h22: idx = 6'd2;   8'h21: idx = 6'd3;
                8'h2a: idx = 6'd4;   8'h1c: idx = 6'd5;   8'h1b: idx = 6'd6;   8'h23: idx = 6'd7;
                8'h2b: idx = 6'd8;   8'h34: idx = 6'd9;   8'h15: idx = 6'd10;  8'h1d: idx = 6'd11;
                8'h24: idx = 6'd12;  8'h2d: idx = 6'd13;  8'h2c: idx = 6'd14;  8'h16: idx = 6'd15;
                8'h1e: idx = 6'd16;  8'h26: idx = 6'd17;  8'h25: idx = 6'd18;  8'h2e: idx = 6'd19;
                8'h45: idx = 6'd20;  8'h46: idx = 6'd21;  8'h3e: idx = 6'd22;  8'h3d: idx = 6'd23;
                8'h36: idx = 6'd24;  8'h4d: idx = 6'd25;  8'h44: idx = 6'd26;  8'h43: idx = 6'd27;
                8'h3c: idx = 6'd28;  8'h35: idx = 6'd29;  8'h5a: idx = 6'd30;  8'h4b: idx = 6'd31;
                8'h42: idx = 6'd32;  8'h3b: idx = 6'd33;  8'h33: idx = 6'd34;  8'h29: idx = 6'd35;
                8'h59, 8'h14: idx = 6'd36;
                8'h3a: idx = 6'd37;  8'h31: idx = 6'd38;  8'h32: idx = 6'd39;
                default: hit = 1'b0;
            endcase
        end
        return {hit, idx};
    endfunction

    // Compound flags: [0] Backspace, [1] Left, [2] Down, [3] Up, [4] Right.
    function automatic logic [4:0] map_cmp(input logic ext, input logic [7:0] code);
        logic [4:0] f;
        f = '0;
        if (!ext && code == 8'h66) f[0] = 1'b1;
        if (ext && code == 8'h6b)  f[1] = 1'b1;
        if (ext && code == 8'h72)  f[2] = 1'b1;
        if (ext && code == 8'h75)  f[3] = 1'b1;
        if (ext && code == 8'h74)  f[4] = 1'b1;
        return f;
    endfunction

    always_comb begin
        clk_filt_d = clk_filt_q;
        clk_cnt_d  = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (clk_cnt_q == FiltW'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
            else                                     clk_cnt_d  = clk_cnt_q + 1'b1;
        end
        dat_filt_d = dat_filt_q;
        dat_cnt_d  = '0;
        if (dat_sync_q[1] != dat_filt_q) begin
            if (dat_cnt_q == FiltW'(FILTER_LEN - 1)) dat_filt_d = dat_sync_q[1];
            else                                     dat_cnt_d  = dat_cnt_q + 1'b1;
        end
    end

    assign strobe = clk_filt_q & ~clk_filt_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        tmo_d        = (state_q == StIdle) ? '0 : tmo_q + 1'b1;
        // A strobe takes priority over a coincident timeout expiry.
        if (strobe) begin
            tmo_d = '0;
            case (state_q)
                StIdle: begin
                    if (!dat_filt_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {dat_filt_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_d   = dat_filt_q;
                    state_d = StStop;
                end
                StStop: begin
                    if (dat_filt_q && (^{shift_q, par_q})) byte_valid_d = 1'b1;
                    else                                   frame_err_d  = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end else if (state_q != StIdle && (&tmo_q)) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
        end
    end

    assign key     = map_key(ext_q, byte_q);
    assign cmp_hit = map_cmp(ext_q, byte_q);

    always_comb begin
        mat_d   = mat_q;
        cmp_d   = cmp_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        magic_d = 1'b0;
        reset_d = 1'b0;
        if (byte_valid_q) begin
            if (byte_q == 8'he0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hf0) begin
                brk_d = 1'b1;
            end else if (byte_q == 8'haa || byte_q == 8'hff) begin
                mat_d = '0;
                cmp_d = '0;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else begin
                if (key[6]) mat_d[key[5:0]] = ~brk_q;
                cmp_d   = brk_q ? (cmp_q & ~cmp_hit) : (cmp_q | cmp_hit);
                magic_d = ~brk_q & ~ext_q & (byte_q == 8'h78);
                reset_d = ~brk_q & ~ext_q & (byte_q == 8'h07);
                ext_d   = 1'b0;
                brk_d   = 1'b0;
            end
        end
    end

    // Compound keys add CS plus their digit without touching the base CS bit.
    always_comb begin
        eff     = mat_q;
        eff[0]  = mat_q[0] | (|cmp_q);
        eff[20] = mat_q[20] | cmp_q[0];
        eff[19] = mat_q[19] | cmp_q[1];
        eff[24] = mat_q[24] | cmp_q[2];
        eff[23] = mat_q[23] | cmp_q[3];
        eff[22] = mat_q[22] | cmp_q[4];
        cols    = '0;
        for (int r = 0; r < 8; r++) begin
            if (!addr_hi[r]) cols = cols | eff[r*5 +: 5];
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            clk_filt_q   <= 1'b1;
            dat_filt_q   <= 1'b1;
            clk_cnt_q    <= '0;
            dat_cnt_q    <= '0;
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            frame_err_q  <= 1'b0;
            mat_q        <= '0;
            cmp_q        <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            magic_q      <= 1'b0;
            reset_q      <= 1'b0;
            kd_q         <= 5'h1f;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk};
            dat_sync_q   <= {dat_sync_q[0], ps2_dat};
            clk_filt_q   <= clk_filt_d;
            dat_filt_q   <= dat_filt_d;
            clk_cnt_q    <= clk_cnt_d;
            dat_cnt_q    <= dat_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            if (byte_valid_d) byte_q <= shift_q;
            frame_err_q  <= frame_err_d;
            mat_q        <= mat_d;
            cmp_q        <= cmp_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            magic_q      <= magic_d;
            reset_q      <= reset_d;
            kd_q         <= ~cols;
        end
    end

    assign kd        = kd_q;
    assign magic_req = magic_q;
    assign reset_req = reset_q;
    assign frame_err = frame_err_q;
endmodule

// File: doc/ps2_keymatrix.md
# ps2_keymatrix

Receives PS/2 set-2 scancodes from the keyboard connector and maintains the 8×5 ZX Spectrum key matrix. Produces the active-low column word `kd[4:0]` for the port #FE read path from the upper address byte of the current I/O cycle. Also raises one-cycle service requests for the magic (NMI) and reset logic. Sits directly upstream of the port decoder, which samples `kd` on every `clk28`.

## Interface
Parameters:
- `FILTER_LEN`, 8: `clk28` cycles a synchronised PS/2 line must hold a new level before it is accepted.
- `TIMEOUT_BITS`, 17: width of the inter-bit timeout counter. Expiry is at 2^17 cycles, about 4.7 ms.

Ports:
- `clk28`  in  1  system clock, 28 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk28`.
- `ps2_dat`  in  1  raw PS/2 data, asynchronous to `clk28`.
- `addr_hi`  in  8  CPU A15..A8. Row r is selected when `addr_hi[r]==0`.
- `kd`  out  5  matrix columns, active-low, registered.
- `magic_req`  out  1  one-cycle pulse on F11 make.
- `reset_req`  out  1  one-cycle pulse on F12 make.
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
Input conditioning:
- Each PS/2 line passes through a 2-FF synchroniser, then a `FILTER_LEN` stability filter.
- A falling edge of the filtered clock is one bit strobe.

Receiver FSM (states IDLE, DATA, PARITY, STOP):
- IDLE: a strobe with dat=0 moves to DATA, bit count cleared. A strobe with dat=1 is ignored.
- DATA: 8 strobes shift data in LSB first, then move to PARITY.
- PARITY: capture the bit; odd parity over data plus this bit is required. Move to STOP.
- STOP: dat=1 with parity good produces a 1-cycle `byte_valid`. Any other combination pulses `frame_err` and discards the byte. Return to IDLE in either case.
- Outside IDLE, the timeout counter clears on every strobe. On expiry, return to IDLE and pulse `frame_err`.

Decoder, processing each valid byte:
- E0 sets `ext`.
- F0 sets `brk`.
- AA or FF (BAT / self-test) clears the whole matrix, `ext` and `brk`.
- Any other byte is a key event: make if `brk==0`, break if `brk==1`. `ext` and `brk` clear after the event.

ZX matrix, bit0→bit4 per row:
- A8: CS Z X C V
- A9: A S D F G
- A10: Q W E R T
- A11: 1 2 3 4 5
- A12: 0 9 8 7 6
- A13: P O I U Y
- A14: ENTER L K J H
- A15: SPACE SS M N B

Key mapping:
- Letters and main-block digits map to the same-labelled ZX key.
- Enter (5A) → ENTER. Space (29) → SPACE.
- L-Shift (12) → CS.
- R-Shift (59), L-Ctrl (14), E0 14 → SS.
- Compound keys each have their own pressed flag: Backspace (66) = CS+0, E0 6B = CS+5, E0 72 = CS+6, E0 75 = CS+7, E0 74 = CS+8.
  - The effective CS bit is base CS OR any compound flag.
  - Releasing an arrow key must not release a physically held Shift.
- F11 (78) make pulses `magic_req`. F12 (07) make pulses `reset_req`. Typematic repeats of these keys pulse again.
- Unmapped codes are ignored.

Column output:
- `kd[b] = ~OR(eff[r][b] for all r with addr_hi[r]==0)`.
- `addr_hi==FF` gives `kd=11111`.

## Timing
- Reset values:
  - `kd=11111`; `magic_req`, `reset_req`, `frame_err` = 0.
  - Matrix, compound flags, `ext`, `brk` all clear; FSM in IDLE; timeout counter 0.
- Latency:
  - Final stop-bit edge on the pins → synchroniser (2) → filter (`FILTER_LEN`) → `byte_valid` (+1) → matrix update (+1) → `kd` (+1).
  - `addr_hi` change → `kd` valid after exactly 1 `clk28`.
- A typematic repeat make on a held key leaves the matrix unchanged.
- Break for a key that is not pressed: no effect.
- `brk` set and then AA received: matrix cleared, `brk` cleared.
- `rst_n` asserted mid-frame: the partial byte is lost. After release the receiver resyncs at the next start bit.
- Simultaneous timeout expiry and strobe: the strobe wins and the counter clears.

## Test plan
- Reset, then `addr_hi=FE` → `kd=11111`. Send 1C (A) → `addr_hi=FD` gives `kd=11110`; `addr_hi=FE` gives `kd=11111`.
- Make 12 (L-Shift), then make E0 75 (Up), then break E0 F0 75 → with `addr_hi=EF`, `kd` goes 11111 → 10111 → 11111. With `addr_hi=FE`, `kd` stays 11110 throughout (CS held by Shift).
- `addr_hi=00` with Q (15) and 1 (16) held → `kd=11110`. Break both → `kd=11111`.
- Frame with a wrong parity bit → `frame_err` pulses once and the matrix is unchanged. Start bit then 8 data bits then silence for 2^17 cycles → `frame_err` pulses and the next good frame decodes correctly.
- Make 78 → `magic_req` high for exactly 1 cycle. Make 07 → `reset_req` high for 1 cycle. Break codes for either key → no pulse.
- Hold 29 (Space), then send AA → with `addr_hi=7F`, `kd` returns to 11111. Assert `rst_n` mid-frame → all outputs at reset values, and the next complete frame decodes.
